// File: rtl/uart_tx_arbiter.sv
// Two-requester 8N1 UART transmitter with round-robin arbitration and WAIT clocks per bit.
// Define UART_TX_ARBITER_FIXED_PRIO_EN to make requester 0 always win when both are valid.
module uart_tx_arbiter #(
  parameter int unsigned WAIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic       last_grant
);

  localparam int unsigned WCW = (WAIT > 1) ? $clog2(WAIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           grant_q, grant_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           pick1, ready0, ready1, bit_end;

  // Winner selection; readies only in IDLE and never while reset is asserted.
  always_comb begin
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
    pick1 = req1_valid && !req0_valid;
`else
    pick1 = req1_valid && (!req0_valid || !grant_q);
`endif
    ready0 = (state_q == IDLE) && !reset && req0_valid && !pick1;
    ready1 = (state_q == IDLE) && !reset && pick1;
  end

  assign bit_end = (wait_q == WCW'(WAIT - 1));

  // State register plus frame datapath and registered line outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      grant_q <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      grant_q <= grant_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        bit_d  = '0;
        if (ready0) begin
          shift_d = req0_data;
          grant_d = 1'b0;
          state_d = START;
        end else if (ready1) begin
          shift_d = req1_data;
          grant_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          wait_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          wait_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          wait_d  = '0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the upcoming cycle, registered so the pin is glitch-free.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign req0_ready = ready0;
  assign req1_ready = ready1;
  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign last_grant = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single board UART transmit line between two byte sources: requester 0 (CPU store path) and requester 1 (debug/echo path).
- Arbitrates between them, accepts one byte per frame over a valid/ready handshake, and serialises it as 8N1, LSB first.
- Each bit lasts WAIT clock cycles; WAIT is the same clocks-per-bit value used by the UART receiver in mother_board.
- Sits between the bus peripherals and the uart_tx top-level pin.

Parameters:
- WAIT, 8, clock cycles per UART bit. Legal range is WAIT >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a byte
- req0_data  input  8  requester 0 byte
- req0_ready  output  1  requester 0 byte accepted this cycle
- req1_valid  input  1  requester 1 has a byte
- req1_data  input  8  requester 1 byte
- req1_ready  output  1  requester 1 byte accepted this cycle
- uart_tx  output  1  serial line; idles high
- busy  output  1  frame in progress
- last_grant  output  1  index of the most recently accepted requester

Behaviour:
- Reset is asynchronous and active-high, on one clock clk. While reset is high:
  - uart_tx=1, busy=0, last_grant=1, state=IDLE;
  - req0_ready=0 and req1_ready=0 (forced low);
  - counters are cleared.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - uart_tx=1, busy=0.
  - The winner is chosen combinationally from the valids in the current cycle.
  - Only one valid high: that requester wins.
  - Both valid high: the requester with index != last_grant wins (round-robin).
  - reqN_ready = IDLE && winner==N && reqN_valid. It is combinational, and at most one ready is high at a time.
  - Transfer happens when valid && ready. On a transfer: the shift register loads the data, last_grant<=N, and state goes to START.
- START: uart_tx=0 for WAIT cycles, then DATA with bit_cnt=0.
- DATA:
  - uart_tx=shift[0] for WAIT cycles.
  - Then shift right, bit_cnt+1.
  - After bit_cnt=7 completes, go to STOP.
- STOP: uart_tx=1 for WAIT cycles, then IDLE.
- busy=1 in START, DATA and STOP. uart_tx and busy are registered outputs.
- Latency:
  - Handshake at cycle N; uart_tx falls and busy rises at edge N+1.
  - A frame occupies exactly 10*WAIT cycles in START+DATA+STOP.
- Back-to-back frames: a minimum of 1 IDLE cycle separates frames, so the effective stop bit is WAIT+1 cycles. The frame-to-frame period is 10*WAIT+1.
- Counters:
  - wait_cnt is $clog2(WAIT) bits wide, counts 0..WAIT-1 and wraps to 0 on each bit boundary.
  - bit_cnt is 3 bits.
- Requester rules:
  - Data must be stable while valid is high, up to and including the accept cycle.
  - valid may drop before acceptance; no byte is sent in that case.
  - Valid asserted while busy is ignored, with ready held low until IDLE.
- Reset mid-frame: uart_tx returns to 1 asynchronously, the frame is abandoned, no ready is issued, and last_grant=1.

Optional Feature:
- Macro: UART_TX_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins when both are valid. last_grant is still updated and output.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Single byte, WAIT=8, req0_valid with 0x0F (req1 idle) -> req0_ready for 1 cycle. uart_tx then shows: 0 for 8 cycles, 1,1,1,1,0,0,0,0 (8 cycles each), 1 for 8 cycles. busy high for exactly 80 cycles; last_grant=0.
- Simultaneous requests: req0=0xA5 and req1=0x3C both valid from reset release -> 0xA5 sent first (last_grant reset value is 1), then 0x3C. A further simultaneous pair after that is served req0 first again.
- Back-to-back: req1 held valid with 0x55 for 3 frames -> falling edges of successive start bits are exactly 81 cycles apart (WAIT=8). req1_ready pulses exactly 3 times.
- Withdrawn request: req0_valid pulsed high for 5 cycles during busy, then dropped -> no req0_ready and no further frame after the current one ends.
- Reset during data bit 3 of byte 0xF0 -> uart_tx=1 and busy=0 in the same cycle reset rises. After release, req1 byte 0x81 transmits intact as a full frame.
- Fixed priority, compiled with UART_TX_ARBITER_FIXED_PRIO_EN, both valid continuously for 4 frames -> only req0 is served and req1_ready stays 0. Without the macro, the 4 frames alternate 0,1,0,1.
